rgmii_rx_deframer: RTL

- Consumes the demultiplexed RGMII receive stream, one byte plus two control bits per `clk` cycle, from the PHY RX DDR demux.
- Strips preamble, SFD and FCS, checks CRC-32, length and PHY error, and presents payload bytes as a valid/last/err stream to the packet logic in top.
- Keeps saturating good-frame and bad-frame counters.

---
 rtl/rgmii_rx_deframer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: strips preamble/SFD/FCS, checks CRC-32, length and PHY
// error, and streams payload bytes with valid/last/err plus good/bad frame counters.
module rgmii_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic [1:0]  rx_ctl,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    localparam logic [10:0] MIN_LEN_C  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C  = 11'(MAX_LEN);
    localparam logic [31:0] CRC_RESID  = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;

    state_t      state_r;
    logic [7:0]  dl_r [0:4];
    logic [2:0]  dl_cnt_r;
    logic [31:0] crc_r;
    logic [10:0] len_r;
    logic        err_r;
    logic [7:0]  out_data_r;
    logic        out_valid_r;
    logic        out_last_r;
    logic        out_err_r;
    logic [15:0] frames_ok_r;
    logic [15:0] frames_bad_r;

    logic        rx_dv_s;
    logic        rx_er_s;
    logic [31:0] crc_next_s;
    logic        frame_bad_s;

    // Reflected CRC-32 update of one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Decode control pair, next CRC and end-of-frame verdict.
    always_comb begin
        rx_dv_s     = rx_ctl[1];
        rx_er_s     = rx_ctl[1] ^ rx_ctl[0];
        crc_next_s  = crc32_byte(crc_r, rx_data);
        frame_bad_s = err_r | (crc_r != CRC_RESID) | (len_r < MIN_LEN_C) | (len_r > MAX_LEN_C);
    end

    // Frame state machine, delay line, checks, outputs and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            for (int i = 0; i < 5; i++) begin
                dl_r[i] <= 8'h00;
            end
            dl_cnt_r     <= 3'd0;
            crc_r        <= 32'hFFFFFFFF;
            len_r        <= 11'd0;
            err_r        <= 1'b0;
            out_data_r   <= 8'h00;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_err_r    <= 1'b0;
            frames_ok_r  <= 16'h0000;
            frames_bad_r <= 16'h0000;
        end else begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE, ST_PREAMBLE: begin
                    // Outside a frame the per-frame context is held clear, so entry to DATA is clean.
                    dl_cnt_r <= 3'd0;
                    crc_r    <= 32'hFFFFFFFF;
                    len_r    <= 11'd0;
                    err_r    <= 1'b0;
                    if (!rx_dv_s) begin
                        state_r <= ST_IDLE;
                    end else if (rx_data == 8'h55) begin
                        state_r <= ST_PREAMBLE;
                    end else if (rx_data == 8'hD5) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (rx_dv_s) begin
                        dl_r[0] <= rx_data;
                        for (int i = 1; i < 5; i++) begin
                            dl_r[i] <= dl_r[i-1];
                        end
                        crc_r <= crc_next_s;
                        if (len_r != 11'd2047) begin
                            len_r <= len_r + 11'd1;
                        end
                        if (rx_er_s) begin
                            err_r <= 1'b1;
                        end
                        if (dl_cnt_r == 3'd5) begin
                            out_data_r  <= dl_r[4];
                            out_valid_r <= 1'b1;
                        end else begin
                            dl_cnt_r <= dl_cnt_r + 3'd1;
                        end
                    end else begin
                        // End of frame: the oldest held byte is the last payload byte, the rest is FCS.
                        if (len_r >= 11'd5) begin
                            out_data_r  <= dl_r[4];
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b1;
                            out_err_r   <= frame_bad_s;
                            if (frame_bad_s) begin
                                frames_bad_r <= sat_inc16(frames_bad_r);
                            end else begin
                                frames_ok_r <= sat_inc16(frames_ok_r);
                            end
                        end else begin
                            frames_bad_r <= sat_inc16(frames_bad_r);
                        end
                        state_r <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!rx_dv_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign out_err    = out_err_r;
    assign frames_ok  = frames_ok_r;
    assign frames_bad = frames_bad_r;

endmodule
